// File: rtl/vblank_task_scheduler.sv
// Frame-periodic task scheduler: per-task frame countdowns raise pending requests,
// which are granted one at a time in fixed index priority with a WAIT timeout.
module vblank_task_scheduler #(
  parameter int NTASK = 4,
  parameter int PW    = 6,
  parameter int TMO   = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vsync,
  input  logic                  en,
  input  logic [NTASK*PW-1:0]   period,
  input  logic [NTASK-1:0]      task_done,
  input  logic                  ovr_clr,
  output logic [NTASK-1:0]      task_start,
  output logic                  busy,
  output logic [7:0]            frame_count,
  output logic                  cursor_blink,
  output logic [NTASK-1:0]      overrun,
  output logic [NTASK-1:0]      timeout_err
);
  localparam int TW = $clog2(TMO + 1);
  localparam int GW = (NTASK > 1) ? $clog2(NTASK) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                    state_q, state_d;
  logic                      vsync_d_q;
  logic [7:0]                frame_count_q, frame_count_d;
  logic [NTASK-1:0][PW-1:0]  cnt_q, cnt_d;
  logic [NTASK-1:0]          pending_q, pending_d;
  logic [GW-1:0]             grant_q, grant_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic [NTASK-1:0]          task_start_q, task_start_d;
  logic [NTASK-1:0]          overrun_q, overrun_d;
  logic [NTASK-1:0]          timeout_q, timeout_d;

  logic                      frame_edge;
  logic [NTASK-1:0]          due;
  logic [NTASK-1:0]          granted;
  logic [NTASK-1:0]          timeout_set;
  logic [GW-1:0]             sel;

  assign frame_edge = vsync_d_q & ~vsync & en;

  // A disabled task parks its countdown at zero so re-enabling makes it due on the next edge.
  genvar gi;
  generate
    for (gi = 0; gi < NTASK; gi++) begin : g_task
      logic [PW-1:0] per;
      assign per        = period[gi*PW +: PW];
      assign due[gi]    = frame_edge && (per != '0) && (cnt_q[gi] == '0);
      assign cnt_d[gi]  = !frame_edge            ? cnt_q[gi] :
                          (per == '0)            ? '0 :
                          (cnt_q[gi] == '0)      ? per - PW'(1) :
                                                   cnt_q[gi] - PW'(1);
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    tmo_d        = tmo_q;
    task_start_d = '0;
    pending_d    = pending_q;
    timeout_set  = '0;
    granted      = '0;
    sel          = '0;

    for (int i = NTASK - 1; i >= 0; i--) begin
      if (pending_q[i]) sel = GW'(i);
    end

    case (state_q)
      IDLE: begin
        if (pending_q != '0) begin
          grant_d           = sel;
          task_start_d[sel] = 1'b1;
          pending_d[sel]    = 1'b0;
          tmo_d             = '0;
          state_d           = WAIT;
        end
      end
      WAIT: begin
        granted[grant_q] = 1'b1;
        if (task_done[grant_q]) begin
          state_d = IDLE;
        end else if (tmo_q == TW'(TMO - 1)) begin
          timeout_set[grant_q] = 1'b1;
          state_d              = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A new due event re-arms pending even when the same task is being granted this cycle.
    pending_d     = pending_d | due;
    overrun_d     = (ovr_clr ? '0 : overrun_q) | (due & (pending_q | granted));
    timeout_d     = (ovr_clr ? '0 : timeout_q) | timeout_set;
    frame_count_d = frame_edge ? frame_count_q + 8'd1 : frame_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      vsync_d_q     <= 1'b0;
      frame_count_q <= '0;
      cnt_q         <= '0;
      pending_q     <= '0;
      grant_q       <= '0;
      tmo_q         <= '0;
      task_start_q  <= '0;
      overrun_q     <= '0;
      timeout_q     <= '0;
    end else begin
      state_q       <= state_d;
      vsync_d_q     <= vsync;
      frame_count_q <= frame_count_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      grant_q       <= grant_d;
      tmo_q         <= tmo_d;
      task_start_q  <= task_start_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
    end
  end

  assign task_start   = task_start_q;
  assign busy         = (state_q == WAIT);
  assign frame_count  = frame_count_q;
  assign cursor_blink = frame_count_q[4];
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_vblank_task_scheduler.sv
// Scoreboard bench: stimulus queues expected start strobes, a monitor pops and compares
// each strobe; a responder returns task_done a programmable number of cycles after start.
module tb_vblank_task_scheduler;
  localparam int NTASK = 4;
  localparam int PW    = 6;
  localparam int TMO   = 1023;

  logic                clk = 1'b0;
  logic                reset;
  logic                vsync;
  logic                en;
  logic [NTASK*PW-1:0] period;
  logic [NTASK-1:0]    task_done;
  logic                ovr_clr;
  logic [NTASK-1:0]    task_start;
  logic                busy;
  logic [7:0]          frame_count;
  logic                cursor_blink;
  logic [NTASK-1:0]    overrun;
  logic [NTASK-1:0]    timeout_err;

  vblank_task_scheduler #(.NTASK(NTASK), .PW(PW), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .en(en), .period(period),
    .task_done(task_done), .ovr_clr(ovr_clr), .task_start(task_start),
    .busy(busy), .frame_count(frame_count), .cursor_blink(cursor_blink),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [NTASK-1:0] exp_q[$];
  int last_start[NTASK];
  int done_delay = -1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (cyc %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every start strobe must match the head of the scoreboard.
  initial begin
    logic [NTASK-1:0] want;
    forever begin
      @(negedge clk);
      if (!reset && task_start != '0) begin
        for (int i = 0; i < NTASK; i++) if (task_start[i]) last_start[i] = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start got=%b want=none (cyc %0d)", task_start, cyc);
        end else begin
          want = exp_q.pop_front();
          if (task_start !== want) begin
            errors++;
            $display("FAIL start_order got=%b want=%b (cyc %0d)", task_start, want, cyc);
          end else begin
            $display("start task_start=%b cyc=%0d ok", task_start, cyc);
          end
        end
      end
    end
  end

  // Responder: task_done pulse done_delay cycles into WAIT; negative delay withholds it.
  initial begin
    int rsp_cnt;
    logic rsp_active;
    logic [NTASK-1:0] rsp_g;
    rsp_active = 1'b0;
    rsp_cnt    = 0;
    rsp_g      = '0;
    task_done  = '0;
    forever begin
      @(negedge clk);
      task_done = '0;
      if (reset) rsp_active = 1'b0;
      else begin
        if (task_start != '0 && done_delay >= 0) begin
          rsp_g = task_start; rsp_cnt = done_delay; rsp_active = 1'b1;
        end
        if (rsp_active) begin
          if (rsp_cnt == 0) begin task_done = rsp_g; rsp_active = 1'b0; end
          else rsp_cnt--;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic set_period(input int p0, input int p1, input int p2, input int p3);
    period[0*PW +: PW] = PW'(p0);
    period[1*PW +: PW] = PW'(p1);
    period[2*PW +: PW] = PW'(p2);
    period[3*PW +: PW] = PW'(p3);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < NTASK; i++) last_start[i] = -1000;
  endtask

  // Returns at the negedge after the edge has been registered.
  task automatic frame();
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int s;
    logic [7:0] fc;
    reset = 1'b1; vsync = 1'b0; en = 1'b1; ovr_clr = 1'b0; period = '0;
    for (int i = 0; i < NTASK; i++) last_start[i] = -1000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_task_start", 32'(task_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_timeout", 32'(timeout_err), 0);

    // Periods 1,2,0,3 over six frames, done three cycles after start.
    set_period(1, 2, 0, 3);
    done_delay = 3;
    do_reset();
    for (int f = 1; f <= 6; f++) begin
      exp_q.push_back(4'b0001);
      if (f % 2 == 1) exp_q.push_back(4'b0010);
      if (f == 1 || f == 4) exp_q.push_back(4'b1000);
      frame();
      repeat (30) @(negedge clk);
    end
    chk("mix_drained", exp_q.size(), 0);
    chk("mix_overrun", 32'(overrun), 0);
    chk("mix_timeout", 32'(timeout_err), 0);
    chk("mix_frames", 32'(frame_count), 6);

    // Same-edge pair with immediate done: second strobe two cycles after first.
    set_period(1, 1, 0, 0);
    done_delay = 0;
    do_reset();
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    frame();
    repeat (10) @(negedge clk);
    chk("pair_drained", exp_q.size(), 0);
    chk("pair_gap", 32'(last_start[1] - last_start[0]), 2);
    chk("pair_busy", 32'(busy), 0);

    // Done withheld: overrun on second edge, then timeout after TMO WAIT cycles.
    set_period(1, 0, 0, 0);
    done_delay = -1;
    do_reset();
    exp_q.push_back(4'b0001);
    frame();
    frame();
    s = last_start[0];
    chk("tmo_overrun", 32'(overrun), 4'b0001);
    chk("tmo_busy_early", 32'(busy), 1);
    done_delay = 0;
    wait_cyc(s + TMO - 1);
    chk("tmo_busy_last", 32'(busy), 1);
    chk("tmo_err_before", 32'(timeout_err), 0);
    exp_q.push_back(4'b0001);
    wait_cyc(s + TMO);
    chk("tmo_busy_after", 32'(busy), 0);
    chk("tmo_err_after", 32'(timeout_err), 4'b0001);
    wait_cyc(s + TMO + 3);
    chk("tmo_regrant_drained", exp_q.size(), 0);
    chk("tmo_regrant_idle", 32'(busy), 0);
    ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    chk("clr_overrun", 32'(overrun), 0);
    chk("clr_timeout", 32'(timeout_err), 0);

    // 256 frames with no tasks: wrap and blink bit.
    set_period(0, 0, 0, 0);
    do_reset();
    for (int f = 1; f <= 256; f++) begin
      frame();
      fc = 8'(f);
      chk("frame_wrap", {frame_count, cursor_blink}, {fc, fc[4]});
    end

    // en low while a task is outstanding: it still completes, nothing else moves.
    set_period(1, 0, 0, 0);
    done_delay = 20;
    do_reset();
    exp_q.push_back(4'b0001);
    frame();
    en = 1'b0;
    frame(); frame(); frame();
    chk("en_count_frozen", 32'(frame_count), 1);
    chk("en_busy_held", 32'(busy), 1);
    repeat (30) @(negedge clk);
    chk("en_busy_done", 32'(busy), 0);
    chk("en_drained", exp_q.size(), 0);
    en = 1'b1;

    // Reset during WAIT, then the first edge restarts every enabled task.
    set_period(1, 2, 0, 0);
    done_delay = -1;
    do_reset();
    exp_q.push_back(4'b0001);
    frame();
    repeat (5) @(negedge clk);
    chk("rw_busy_before", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("rw_task_start", 32'(task_start), 0);
    chk("rw_busy", 32'(busy), 0);
    chk("rw_frame_count", 32'(frame_count), 0);
    chk("rw_overrun", 32'(overrun), 0);
    chk("rw_timeout", 32'(timeout_err), 0);
    done_delay = 2;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    frame();
    repeat (20) @(negedge clk);
    chk("rw_drained", exp_q.size(), 0);
    chk("rw_idle", 32'(busy), 0);
    chk("rw_frames", 32'(frame_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vblank_task_scheduler.md
VBLANK_TASK_SCHEDULER -- requirements
Module: vblank_task_scheduler

Interface
REQ-001 Parameter NTASK, 4, number of frame-periodic requesters (tasks); fixed index priority, task 0 highest.
REQ-002 Parameter PW, 6, width of each per-task period field and countdown.
REQ-003 Parameter TMO, 1023, maximum WAIT-state cycles before a task is aborted.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 vsync  in  1  vertical sync from VGA timing, synchronous to clk; frame boundary = falling edge.
REQ-007 en  in  1  scheduler enable; 0 = frame edges ignored.
REQ-008 period  in  NTASK*PW  per-task period in frames, task i at bits [i*PW +: PW]; 0 = task disabled.
REQ-009 task_done  in  NTASK  completion pulse/level from each task.
REQ-010 ovr_clr  in  1  clears all overrun and timeout flags when high.
REQ-011 task_start  out  NTASK  one-hot, one-cycle start strobe to the granted task.
REQ-012 busy  out  1  high while a granted task is outstanding.
REQ-013 frame_count  out  8  frame counter.
REQ-014 cursor_blink  out  1  equals frame_count[4].
REQ-015 overrun  out  NTASK  sticky: task i came due again before previous instance was served.
REQ-016 timeout_err  out  NTASK  sticky: task i exceeded TMO cycles without task_done.

Function
REQ-017 vsync SHALL be registered (vsync_d); frame_edge = vsync_d & ~vsync & en, evaluated combinationally each cycle.
REQ-018 On frame_edge, frame_count SHALL increment by 1, wrapping 255 -> 0.
REQ-019 Per task, a PW-bit countdown: on frame_edge, if period[i]==0 hold count at 0, no due event; else if count==0 task is due and count loads period[i]-1; else count decrements.
REQ-020 Period changes SHALL take effect at the next reload only; period 1 = due every frame.
REQ-021 Due task i SHALL set pending[i] at the same clock edge; visible next cycle.
REQ-022 If task i becomes due while pending[i]==1 or task i is currently granted, overrun[i] SHALL set; pending[i] stays 1 (no queuing depth beyond 1).
REQ-023 FSM states: IDLE, WAIT.
REQ-024 IDLE: if pending!=0, select g = lowest set index, register task_start = (1<<g), clear pending[g], clear timeout counter, go WAIT; else stay, task_start=0.
REQ-025 task_start SHALL be high for exactly the first WAIT cycle, then 0.
REQ-026 WAIT: task_done[g]==1 (including first WAIT cycle) -> IDLE; task_done of other indices ignored.
REQ-027 WAIT: otherwise timeout counter increments; at counter==TMO-1 without done, set timeout_err[g], go IDLE.
REQ-028 busy SHALL equal (state==WAIT).
REQ-029 Earliest next grant is the cycle after return to IDLE (minimum 2 cycles per task grant); back-to-back pending tasks served in priority order.
REQ-030 frame_edge coinciding with grant of the same task: pending clears for the grant, and the new due event sets overrun[g] (task granted) with pending[g] re-set.
REQ-031 en=0 SHALL not abort an outstanding grant; pending tasks continue to be served; only new due events and frame_count stop.
REQ-032 ovr_clr SHALL clear overrun and timeout_err; a set event in the same cycle wins.

Reset
REQ-033 On reset: state IDLE, vsync_d=0, frame_count=0, all countdowns=0, pending=0, task_start=0, busy=0, overrun=0, timeout_err=0; reset mid-WAIT abandons the grant with no strobe.
REQ-034 First frame_edge after reset SHALL make every task with nonzero period due.

Verification
REQ-035 period={1,2,0,3}, done returned 3 cycles after start, 6 frames -> task0 starts 6x, task1 3x, task2 0x, task3 2x; overrun=0.
REQ-036 Two tasks due on same edge -> task_start 0001 then 0010, second strobe exactly 1 cycle after task0 done accepted.
REQ-037 task0 period 1, task_done withheld across two frame edges -> overrun[0]=1; after TMO=1023 WAIT cycles timeout_err[0]=1, busy=0.
REQ-038 256 frame edges -> frame_count wraps to 0; cursor_blink toggles every 16 frames.
REQ-039 en=0 during task WAIT with 3 frame edges -> task completes normally, frame_count unchanged, no new strobes.
REQ-040 reset asserted in WAIT -> next cycle all outputs at reset values; subsequent first edge restarts all enabled tasks.
